gb_irq_ctrl: RTL and testbench
==============================

GB_IRQ_CTRL -- requirements
Module: gb_irq_ctrl

Interface
REQ-001 Parameter NUM_IRQ, default 5, meaning number of interrupt sources (legal range 1..8).
REQ-002 Parameter SRC_EDGE, default 5'b00001, meaning per-source detect mode: bit=1 rising-edge detect, bit=0 single-cycle pulse input.
REQ-003 Parameter VEC_BASE, default 8'h40, meaning vector of source 0.
REQ-004 Parameter VEC_STRIDE, default 8, meaning vector spacing between sources.
REQ-005 Parameter IDLE_VEC, default 8'h55, meaning vector returned when no enabled source is pending.
REQ-006 clk_sys  in  1  system clock; all state updates on its rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 ce  in  1  clock enable; state advances only in cycles with ce=1.
REQ-009 irq_src  in  NUM_IRQ  raw source lines (pulse or level, per SRC_EDGE).
REQ-010 cpu_sel_ie  in  1  CPU addresses IE ($FFFF).
REQ-011 cpu_sel_if  in  1  CPU addresses IF ($FF0F).
REQ-012 cpu_wr  in  1  CPU write strobe.
REQ-013 cpu_di  in  8  CPU write data.
REQ-014 cpu_do  out  8  register read data.
REQ-015 irq_ack  in  1  CPU interrupt acknowledge (IORQ and M1 both active).
REQ-016 irq_n  out  1  active-low interrupt request to the CPU.
REQ-017 irq_vec  out  8  vector driven to the CPU data bus during acknowledge.
REQ-018 lost_cnt  out  8  count of dropped events (see Configuration).

Function
REQ-019 Event: for an edge-mode source, irq_src[i]=1 in the current enabled cycle and 0 in the previous one; for a pulse-mode source, irq_src[i]=1 in an enabled cycle.
REQ-020 An event on source i shall set if_r[i] on the same enabled edge.
REQ-021 irq_n shall be 0 when (ie_r & if_r) is nonzero and not in ACK state, and 1 otherwise; it is combinational from registers.
REQ-022 The pending index is the lowest i with if_r[i] & ie_r[i]. Source 0 has the highest priority.
REQ-023 The vector is VEC_BASE + VEC_STRIDE*index, computed modulo 256. It is IDLE_VEC when nothing is pending.
REQ-024 FSM states: IDLE, ACK, CLR.
- IDLE->ACK on irq_ack=1. On this transition, latch the index and vector and set a valid flag (valid only if something was pending).
- ACK->CLR when irq_ack returns to 0.
- CLR->IDLE unconditionally after one enabled cycle.
REQ-025 In ACK, irq_vec shall hold the latched vector, stable even if if_r or ie_r change. In IDLE and CLR, irq_vec shows the live vector.
REQ-026 On entry to CLR with valid=1, clear if_r[latched index] only. With valid=0, clear nothing.
REQ-027 IE write (cpu_sel_ie & cpu_wr) shall load ie_r from cpu_di[NUM_IRQ-1:0]. IF write shall load if_r from cpu_di[NUM_IRQ-1:0].
REQ-028 Priority on the same if_r bit in one cycle, highest first: hardware event set, then CPU IF write, then ack clear.
REQ-029 IE and IF writes shall take effect in any FSM state.
REQ-030 cpu_do read mapping:
- cpu_sel_ie: {zeros, ie_r}.
- cpu_sel_if: {ones, if_r}.
- otherwise: 8'hFF.
- Combinational, no read latency.
REQ-031 With ce=0, all registers and edge-history flops shall hold.

Reset
REQ-032 While reset_n=0: ie_r=0, if_r=0, edge-history=0, FSM=IDLE, latched vector=IDLE_VEC, valid=0, lost_cnt=0; therefore irq_n=1 and irq_vec=IDLE_VEC.
REQ-033 Reset asserted mid-acknowledge shall abort to IDLE with no clear performed.

Configuration
REQ-034 Macro GB_IRQ_LOST_CNT_EN defined: lost_cnt shall increment by 1 (saturating at 8'hFF) for each enabled cycle in which at least one event arrives on a source whose if_r bit is already 1 and is not being cleared in that cycle.
- Writing cpu_di with cpu_sel_if & cpu_wr while cpu_di[7]... does not affect it; lost_cnt clears only on reset.
REQ-035 Macro undefined: lost_cnt shall be constant 8'h00 and no counter logic shall be present.

Verification
REQ-036 Defaults; ie=5'h1F; pulse on src[2] -> if_r=5'h04, irq_n=0, irq_vec=8'h50.
REQ-037 Pending 5'h06 with ie=5'h1F; assert irq_ack, then raise src[0] -> irq_vec stays 8'h48; after ack release, if_r=5'h05 and the next vector is 8'h40.
REQ-038 src[0] held high 10 cycles (edge mode) -> exactly one set; IF write 0, still high -> no re-set until a new 0->1 edge.
REQ-039 Same cycle: IF write 8'h00 and pulse on src[3] -> if_r=5'h08; read of IF -> 8'hE8; read of IE with ie=5'h1F -> 8'h1F.
REQ-040 ack with ie=0 -> irq_vec=8'h55 and if_r unchanged. With GB_IRQ_LOST_CNT_EN, 300 pulses on src[1] while if_r[1]=1 -> lost_cnt=8'hFF.
REQ-041 reset_n pulled low during ACK -> FSM=IDLE, irq_n=1, all registers 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/gb_irq_ctrl_if.sv
// CPU-side register bus and interrupt handshake for gb_irq_ctrl.
// The master is the CPU side and the slave is the controller.
interface gb_irq_ctrl_if;
  logic       cpu_sel_ie;
  logic       cpu_sel_if;
  logic       cpu_wr;
  logic [7:0] cpu_di;
  logic [7:0] cpu_do;
  logic       irq_ack;
  logic       irq_n;
  logic [7:0] irq_vec;

  modport master (
    output cpu_sel_ie, cpu_sel_if, cpu_wr, cpu_di, irq_ack,
    input  cpu_do, irq_n, irq_vec
  );

  modport slave (
    input  cpu_sel_ie, cpu_sel_if, cpu_wr, cpu_di, irq_ack,
    output cpu_do, irq_n, irq_vec
  );
endinterface

// File: rtl/gb_irq_ctrl.sv
// Game Boy style IE/IF interrupt controller with a vectored acknowledge FSM.
// Optional dropped-event counter: define GB_IRQ_LOST_CNT_EN.
module gb_irq_ctrl #(
  parameter int unsigned          NUM_IRQ    = 5,
  parameter logic [NUM_IRQ-1:0]   SRC_EDGE   = NUM_IRQ'(5'b00001),
  parameter logic [7:0]           VEC_BASE   = 8'h40,
  parameter int unsigned          VEC_STRIDE = 8,
  parameter logic [7:0]           IDLE_VEC   = 8'h55
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic               ce,
  input  logic [NUM_IRQ-1:0] irq_src,
  gb_irq_ctrl_if.slave       cpu,
  output logic [7:0]         lost_cnt
);

  typedef enum logic [1:0] {IDLE, ACK, CLR} state_t;

  state_t             state;
  logic [NUM_IRQ-1:0] ie_r, if_r, src_q;
  logic [NUM_IRQ-1:0] evt, pend, clr_mask, if_nxt;
  logic [2:0]         pend_idx, idx_q;
  logic               pend_any, valid_q;
  logic [7:0]         live_vec, vec_q;
  logic               ie_wr, if_wr;
  logic               unused_di;

  assign ie_wr     = cpu.cpu_sel_ie & cpu.cpu_wr;
  assign if_wr     = cpu.cpu_sel_if & cpu.cpu_wr;
  assign unused_di = &{1'b0, cpu.cpu_di};

  // Edge-mode bits need a 0->1 against history; pulse-mode bits pass straight through.
  assign evt  = irq_src & (~SRC_EDGE | ~src_q);
  assign pend = ie_r & if_r;

  always_comb begin
    pend_idx = '0;
    pend_any = 1'b0;
    for (int unsigned i = NUM_IRQ; i > 0; i--) begin
      if (pend[i-1]) begin
        pend_idx = 3'(i - 1);
        pend_any = 1'b1;
      end
    end
  end

  assign live_vec = pend_any ? 8'(32'(VEC_BASE) + VEC_STRIDE * 32'(pend_idx)) : IDLE_VEC;

  assign clr_mask = (state == ACK && !cpu.irq_ack && valid_q) ? (NUM_IRQ'(1) << idx_q) : '0;

  // Event set wins over a CPU write, which wins over the acknowledge clear.
  assign if_nxt = (if_wr ? cpu.cpu_di[NUM_IRQ-1:0] : (if_r & ~clr_mask)) | evt;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      ie_r    <= '0;
      if_r    <= '0;
      src_q   <= '0;
      idx_q   <= '0;
      vec_q   <= IDLE_VEC;
      valid_q <= 1'b0;
    end else if (ce) begin
      src_q <= irq_src;
      if_r  <= if_nxt;
      if (ie_wr) ie_r <= cpu.cpu_di[NUM_IRQ-1:0];
      case (state)
        IDLE: if (cpu.irq_ack) begin
          state   <= ACK;
          idx_q   <= pend_idx;
          vec_q   <= live_vec;
          valid_q <= pend_any;
        end
        ACK:     if (!cpu.irq_ack) state <= CLR;
        CLR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign cpu.irq_n   = ~(pend_any && state != ACK);
  assign cpu.irq_vec = (state == ACK) ? vec_q : live_vec;

  always_comb begin
    cpu.cpu_do = '1;
    if (cpu.cpu_sel_ie) begin
      cpu.cpu_do = '0;
      cpu.cpu_do[NUM_IRQ-1:0] = ie_r;
    end else if (cpu.cpu_sel_if) begin
      cpu.cpu_do[NUM_IRQ-1:0] = if_r;
    end
  end

`ifdef GB_IRQ_LOST_CNT_EN
  logic [7:0] lost_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      lost_q <= '0;
    end else if (ce && (|(evt & if_r & ~clr_mask)) && lost_q != '1) begin
      lost_q <= lost_q + 8'd1;
    end
  end

  assign lost_cnt = lost_q;
`else
  assign lost_cnt = '0;
`endif

endmodule

// File: tb/tb_gb_irq_ctrl.sv
// Self-checking bench for gb_irq_ctrl: directed vector table, corner sequences,
// and randomized traffic against a behavioural reference model.
module tb_gb_irq_ctrl;
  localparam int         NI        = 5;
  localparam logic [4:0] EDGE_MASK = 5'b00001;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       ce      = 1'b0;
  logic [4:0] irq_src = '0;
  logic [7:0] lost_cnt;

  gb_irq_ctrl_if bus();

  gb_irq_ctrl #(
    .NUM_IRQ   (5),
    .SRC_EDGE  (5'b00001),
    .VEC_BASE  (8'h40),
    .VEC_STRIDE(8),
    .IDLE_VEC  (8'h55)
  ) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .ce      (ce),
    .irq_src (irq_src),
    .cpu     (bus),
    .lost_cnt(lost_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: IE/IF as plain bit sets, acknowledge as in-progress/cool-down flags.
  logic [4:0] m_ie, m_if, m_prev;
  bit         m_acking, m_cool, m_have;
  int         m_idx;
  logic [7:0] m_vec;
  int         m_lost;

  function automatic int m_pend();
    for (int i = 0; i < NI; i++) if (m_ie[i] && m_if[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] m_vecof(input int idx);
    if (idx < 0) return 8'h55;
    return 8'((64 + 8 * idx) % 256);
  endfunction

  task automatic m_reset();
    m_ie = '0; m_if = '0; m_prev = '0;
    m_acking = 0; m_cool = 0; m_have = 0; m_idx = 0;
    m_vec = 8'h55; m_lost = 0;
  endtask

  task automatic m_step();
    logic [4:0] ev, clr;
    int p;
    if (!ce) return;
    p = m_pend();
    for (int i = 0; i < NI; i++) ev[i] = irq_src[i] && (!EDGE_MASK[i] || !m_prev[i]);
    clr = '0;
    if (m_acking && !bus.irq_ack && m_have) clr[m_idx] = 1'b1;
`ifdef GB_IRQ_LOST_CNT_EN
    if ((ev & m_if & ~clr) != 5'b0 && m_lost < 255) m_lost++;
`endif
    if (bus.cpu_sel_if && bus.cpu_wr) m_if = bus.cpu_di[4:0];
    else m_if = m_if & ~clr;
    m_if = m_if | ev;
    if (bus.cpu_sel_ie && bus.cpu_wr) m_ie = bus.cpu_di[4:0];
    if (m_cool) m_cool = 0;
    else if (m_acking) begin
      if (!bus.irq_ack) begin m_acking = 0; m_cool = 1; end
    end else if (bus.irq_ack) begin
      m_acking = 1;
      m_have   = (p >= 0);
      m_idx    = (p < 0) ? 0 : p;
      m_vec    = m_vecof(p);
    end
    m_prev = irq_src;
  endtask

  function automatic logic [7:0] m_do();
    if (bus.cpu_sel_ie) return {3'b000, m_ie};
    if (bus.cpu_sel_if) return {3'b111, m_if};
    return 8'hFF;
  endfunction

  task automatic drive(input logic c, input logic [4:0] s, input logic sie, input logic sif,
                       input logic wr, input logic [7:0] di, input logic ack);
    ce = c; irq_src = s;
    bus.cpu_sel_ie = sie; bus.cpu_sel_if = sif; bus.cpu_wr = wr;
    bus.cpu_di = di; bus.irq_ack = ack;
  endtask

  task automatic tick();
    m_step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 5'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    reset_n = 1'b0;
    m_reset();
    @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    chk("reset_irq_n", {7'b0, bus.irq_n}, 8'h01);
    chk("reset_vec", bus.irq_vec, 8'h55);
    chk("reset_if", bus.cpu_do, 8'hE0);
    chk("reset_lost", lost_cnt, 8'h00);
  endtask

  typedef struct {
    logic       ce;
    logic [4:0] src;
    logic       sie, sif, wr;
    logic [7:0] di;
    logic       ack;
    logic       irq_n;
    logic [7:0] vec;
    logic [7:0] dout;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{1'b1, 5'h00, 1'b1, 1'b0, 1'b1, 8'h1F, 1'b0, 1'b1, 8'h55, 8'h1F};
    tbl[1] = '{1'b1, 5'h04, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h50, 8'hE4};
    tbl[2] = '{1'b0, 5'h01, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h50, 8'hE4};
    tbl[3] = '{1'b1, 5'h01, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h40, 8'hE5};
    tbl[4] = '{1'b1, 5'h09, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h58, 8'hE8};
    tbl[5] = '{1'b1, 5'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h58, 8'h1F};
    tbl[6] = '{1'b1, 5'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h55, 8'h00};
    tbl[7] = '{1'b1, 5'h00, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 8'h55, 8'hFF};
    tbl[8] = '{1'b1, 5'h00, 1'b1, 1'b0, 1'b1, 8'hE2, 1'b0, 1'b0, 8'h48, 8'h02};
    tbl[9] = '{1'b1, 5'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h48, 8'hFF};

    // Directed vector table
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].ce, tbl[i].src, tbl[i].sie, tbl[i].sif, tbl[i].wr, tbl[i].di, tbl[i].ack);
      tick();
      chk($sformatf("tbl%0d_irq_n", i), {7'b0, bus.irq_n}, {7'b0, tbl[i].irq_n});
      chk($sformatf("tbl%0d_vec", i), bus.irq_vec, tbl[i].vec);
      chk($sformatf("tbl%0d_do", i), bus.cpu_do, tbl[i].dout);
    end

    // Vector stays latched through acknowledge; only the acknowledged bit clears
    do_reset();
    drive(1'b1, 5'h00, 1'b1, 1'b0, 1'b1, 8'h1F, 1'b0); tick();
    drive(1'b1, 5'h00, 1'b0, 1'b1, 1'b1, 8'h06, 1'b0); tick();
    drive(1'b1, 5'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1); tick();
    chk("ack_vec", bus.irq_vec, 8'h48);
    chk("ack_irq_n", {7'b0, bus.irq_n}, 8'h01);
    drive(1'b1, 5'h01, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1); tick();
    chk("ack_vec_hold", bus.irq_vec, 8'h48);
    chk("ack_if_set", bus.cpu_do, 8'hE7);
    drive(1'b1, 5'h01, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0); tick();
    chk("clr_if", bus.cpu_do, 8'hE5);
    chk("clr_vec", bus.irq_vec, 8'h40);
    chk("clr_irq_n", {7'b0, bus.irq_n}, 8'h00);
    tick();
    chk("idle_vec", bus.irq_vec, 8'h40);
    chk("idle_if", bus.cpu_do, 8'hE5);

    // Edge-mode source held high sets once only
    do_reset();
    drive(1'b1, 5'h00, 1'b1, 1'b0, 1'b1, 8'h1F, 1'b0); tick();
    drive(1'b1, 5'h01, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    chk("held_once", bus.cpu_do, 8'hE1);
    drive(1'b1, 5'h01, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0); tick();
    chk("held_wr0", bus.cpu_do, 8'hE0);
    drive(1'b1, 5'h01, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    chk("held_noreset", bus.cpu_do, 8'hE0);
    drive(1'b1, 5'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0); tick();
    drive(1'b1, 5'h01, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0); tick();
    chk("new_edge", bus.cpu_do, 8'hE1);
    chk("edge_lost", lost_cnt, 8'h00);

    // Acknowledge with nothing enabled, then repeated events on an already-set bit
    do_reset();
    drive(1'b1, 5'h00, 1'b0, 1'b1, 1'b1, 8'h02, 1'b0); tick();
    drive(1'b1, 5'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1); tick();
    chk("ie0_ack_vec", bus.irq_vec, 8'h55);
    drive(1'b1, 5'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0); tick();
    chk("ie0_clr_if", bus.cpu_do, 8'hE2);
    tick();
    chk("ie0_idle_if", bus.cpu_do, 8'hE2);
    drive(1'b1, 5'h02, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0); tick();
`ifdef GB_IRQ_LOST_CNT_EN
    chk("lost_one", lost_cnt, 8'h01);
`else
    chk("lost_one", lost_cnt, 8'h00);
`endif
    for (int i = 0; i < 299; i++) tick();
`ifdef GB_IRQ_LOST_CNT_EN
    chk("lost_sat", lost_cnt, 8'hFF);
`else
    chk("lost_sat", lost_cnt, 8'h00);
`endif
    chk("lost_if", bus.cpu_do, 8'hE2);

    // Asynchronous reset in the middle of an acknowledge
    do_reset();
    drive(1'b1, 5'h00, 1'b1, 1'b0, 1'b1, 8'h1F, 1'b0); tick();
    drive(1'b1, 5'h00, 1'b0, 1'b1, 1'b1, 8'h04, 1'b0); tick();
    drive(1'b1, 5'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1); tick();
    chk("pre_rst_vec", bus.irq_vec, 8'h50);
    chk("pre_rst_irq_n", {7'b0, bus.irq_n}, 8'h01);
    #2 reset_n = 1'b0;
    #1;
    chk("async_irq_n", {7'b0, bus.irq_n}, 8'h01);
    chk("async_vec", bus.irq_vec, 8'h55);
    chk("async_if", bus.cpu_do, 8'hE0);
    bus.cpu_sel_ie = 1'b1; bus.cpu_sel_if = 1'b0;
    #1;
    chk("async_ie", bus.cpu_do, 8'h00);
    m_reset();
    #1 reset_n = 1'b1;
    drive(1'b1, 5'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0); tick();
    chk("post_rst_if", bus.cpu_do, 8'hE0);
    chk("post_rst_irq_n", {7'b0, bus.irq_n}, 8'h01);

    // Randomized traffic against the model
    do_reset();
    begin
      logic ack_r;
      ack_r = 1'b0;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(5) == 0) ack_r = ~ack_r;
        drive(($urandom_range(3) != 0), 5'($urandom), ($urandom_range(7) == 0),
              ($urandom_range(7) == 0), 1'($urandom), 8'($urandom), ack_r);
        tick();
        chk("rnd_irq_n", {7'b0, bus.irq_n}, {7'b0, ~(m_pend() >= 0 && !m_acking)});
        chk("rnd_vec", bus.irq_vec, m_acking ? m_vec : m_vecof(m_pend()));
        chk("rnd_do", bus.cpu_do, m_do());
        chk("rnd_lost", lost_cnt, 8'(m_lost));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
